// File: rtl/alu_exec_unit.sv
// Integer/branch execution stage: one RV32I op per cycle from the reservation
// station, result broadcast on the ALU CDB port one cycle later.
module alu_exec_unit #(
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 5,
  parameter int OP_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback_signal,
  input  logic [OP_W-1:0]     optype_in,
  input  logic [ROB_ID_W-1:0] rd_in,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   vi_in,
  input  logic [DATA_W-1:0]   vj_in,
  input  logic [DATA_W-1:0]   imm_in,
  output logic                alu_has_result,
  output logic [ROB_ID_W-1:0] alias_out,
  output logic [DATA_W-1:0]   result_out,
  output logic                is_branch_out,
  output logic                taken_out,
  output logic [DATA_W-1:0]   target_pc_out
);

  localparam logic [OP_W-1:0] NOP          = 6'd0;
  localparam logic [OP_W-1:0] OPTYPE_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OPTYPE_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OPTYPE_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OPTYPE_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OPTYPE_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OPTYPE_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OPTYPE_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OPTYPE_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OPTYPE_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OPTYPE_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OPTYPE_ADDI  = 6'd11;
  localparam logic [OP_W-1:0] OPTYPE_SLTI  = 6'd12;
  localparam logic [OP_W-1:0] OPTYPE_SLTIU = 6'd13;
  localparam logic [OP_W-1:0] OPTYPE_XORI  = 6'd14;
  localparam logic [OP_W-1:0] OPTYPE_ORI   = 6'd15;
  localparam logic [OP_W-1:0] OPTYPE_ANDI  = 6'd16;
  localparam logic [OP_W-1:0] OPTYPE_SLLI  = 6'd17;
  localparam logic [OP_W-1:0] OPTYPE_SRLI  = 6'd18;
  localparam logic [OP_W-1:0] OPTYPE_SRAI  = 6'd19;
  localparam logic [OP_W-1:0] OPTYPE_ADD   = 6'd20;
  localparam logic [OP_W-1:0] OPTYPE_SUB   = 6'd21;
  localparam logic [OP_W-1:0] OPTYPE_SLL   = 6'd22;
  localparam logic [OP_W-1:0] OPTYPE_SLT   = 6'd23;
  localparam logic [OP_W-1:0] OPTYPE_SLTU  = 6'd24;
  localparam logic [OP_W-1:0] OPTYPE_XOR   = 6'd25;
  localparam logic [OP_W-1:0] OPTYPE_SRL   = 6'd26;
  localparam logic [OP_W-1:0] OPTYPE_SRA   = 6'd27;
  localparam logic [OP_W-1:0] OPTYPE_OR    = 6'd28;
  localparam logic [OP_W-1:0] OPTYPE_AND   = 6'd29;

  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] FOUR = {{(DATA_W-3){1'b0}}, 3'b100};

  logic [DATA_W-1:0] res_c;
  logic [DATA_W-1:0] tgt_c;
  logic              br_c;
  logic              tk_c;
  logic [4:0]        sh_r;
  logic [4:0]        sh_i;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] pc_plus_imm;
  logic              lt_s;
  logic              lt_u;
  logic              lt_si;
  logic              lt_ui;

  assign sh_r        = vj_in[4:0];
  assign sh_i        = imm_in[4:0];
  assign pc_plus4    = pc_in + FOUR;
  assign pc_plus_imm = pc_in + imm_in;
  assign lt_s        = $signed(vi_in) < $signed(vj_in);
  assign lt_u        = vi_in < vj_in;
  assign lt_si       = $signed(vi_in) < $signed(imm_in);
  assign lt_ui       = vi_in < imm_in;

  // Unrecognised optypes fall through the defaults: result 0, not a branch.
  always_comb begin
    res_c = '0;
    tgt_c = pc_plus4;
    br_c  = 1'b0;
    tk_c  = 1'b0;
    unique case (optype_in)
      OPTYPE_LUI:   res_c = imm_in;
      OPTYPE_AUIPC: res_c = pc_plus_imm;
      OPTYPE_JAL: begin
        res_c = pc_plus4;
        br_c  = 1'b1;
        tk_c  = 1'b1;
        tgt_c = pc_plus_imm;
      end
      OPTYPE_JALR: begin
        res_c = pc_plus4;
        br_c  = 1'b1;
        tk_c  = 1'b1;
        tgt_c = (vi_in + imm_in) & ~ONE;
      end
      OPTYPE_BEQ:  begin br_c = 1'b1; tk_c = (vi_in == vj_in); end
      OPTYPE_BNE:  begin br_c = 1'b1; tk_c = (vi_in != vj_in); end
      OPTYPE_BLT:  begin br_c = 1'b1; tk_c = lt_s;  end
      OPTYPE_BGE:  begin br_c = 1'b1; tk_c = !lt_s; end
      OPTYPE_BLTU: begin br_c = 1'b1; tk_c = lt_u;  end
      OPTYPE_BGEU: begin br_c = 1'b1; tk_c = !lt_u; end
      OPTYPE_ADDI:  res_c = vi_in + imm_in;
      OPTYPE_SLTI:  res_c = lt_si ? ONE : '0;
      OPTYPE_SLTIU: res_c = lt_ui ? ONE : '0;
      OPTYPE_XORI:  res_c = vi_in ^ imm_in;
      OPTYPE_ORI:   res_c = vi_in | imm_in;
      OPTYPE_ANDI:  res_c = vi_in & imm_in;
      OPTYPE_SLLI:  res_c = vi_in << sh_i;
      OPTYPE_SRLI:  res_c = vi_in >> sh_i;
      OPTYPE_SRAI:  res_c = $unsigned($signed(vi_in) >>> sh_i);
      OPTYPE_ADD:   res_c = vi_in + vj_in;
      OPTYPE_SUB:   res_c = vi_in - vj_in;
      OPTYPE_SLL:   res_c = vi_in << sh_r;
      OPTYPE_SLT:   res_c = lt_s ? ONE : '0;
      OPTYPE_SLTU:  res_c = lt_u ? ONE : '0;
      OPTYPE_XOR:   res_c = vi_in ^ vj_in;
      OPTYPE_SRL:   res_c = vi_in >> sh_r;
      OPTYPE_SRA:   res_c = $unsigned($signed(vi_in) >>> sh_r);
      OPTYPE_OR:    res_c = vi_in | vj_in;
      OPTYPE_AND:   res_c = vi_in & vj_in;
      default: ;
    endcase
    if (br_c && tk_c && optype_in != OPTYPE_JALR)
      tgt_c = pc_plus_imm;
  end

  always_ff @(posedge clk) begin
    if (rst || rollback_signal) begin
      alu_has_result <= 1'b0;
      alias_out      <= '0;
      result_out     <= '0;
      is_branch_out  <= 1'b0;
      taken_out      <= 1'b0;
      target_pc_out  <= '0;
    end else if (rdy) begin
      alu_has_result <= (optype_in != NOP);
      alias_out      <= rd_in;
      result_out     <= res_c;
      is_branch_out  <= br_c;
      taken_out      <= tk_c;
      target_pc_out  <= tgt_c;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single ops plus
// sequences for back-to-back issue, rollback and rdy stall.
module tb_alu_exec_unit;

  localparam logic [5:0] NOP = 6'd0, LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
  localparam logic [5:0] BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, BLTU = 6'd9, BGEU = 6'd10;
  localparam logic [5:0] ADDI = 6'd11, XORI = 6'd14, SLLI = 6'd17, SRAI = 6'd19;
  localparam logic [5:0] ADD = 6'd20, SUB = 6'd21, SLT = 6'd23, SLTU = 6'd24, SRL = 6'd26, SRA = 6'd27;
  localparam logic [5:0] BOGUS = 6'h3F;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback_signal;
  logic [5:0]  optype_in;
  logic [4:0]  rd_in;
  logic [31:0] pc_in, vi_in, vj_in, imm_in;
  logic        alu_has_result, is_branch_out, taken_out;
  logic [4:0]  alias_out;
  logic [31:0] result_out, target_pc_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
    .optype_in(optype_in), .rd_in(rd_in), .pc_in(pc_in), .vi_in(vi_in),
    .vj_in(vj_in), .imm_in(imm_in), .alu_has_result(alu_has_result),
    .alias_out(alias_out), .result_out(result_out), .is_branch_out(is_branch_out),
    .taken_out(taken_out), .target_pc_out(target_pc_out)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc, vi, vj, imm;
    logic [31:0] res;
    logic        br, tk;
    logic [31:0] tgt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] vi, input logic [31:0] vj, input logic [31:0] imm);
    optype_in = op; rd_in = rd; pc_in = pc; vi_in = vi; vj_in = vj; imm_in = imm;
  endtask

  // Inputs change 1 time unit after a posedge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic has, input logic [4:0] al,
                           input logic [31:0] res, input logic br, input logic tk,
                           input logic [31:0] tgt);
    check({tag, ".has"}, 32'(alu_has_result), 32'(has));
    check({tag, ".alias"}, 32'(alias_out), 32'(al));
    check({tag, ".res"}, result_out, res);
    check({tag, ".br"}, 32'(is_branch_out), 32'(br));
    check({tag, ".tk"}, 32'(taken_out), 32'(tk));
    check({tag, ".tgt"}, target_pc_out, tgt);
  endtask

  vec_t vecs[$];

  initial begin
    //            op     rd  pc        vi            vj            imm           res           br tk tgt
    vecs.push_back('{ADD,   3, 32'h0,     32'd5,        32'd7,        32'h0,        32'd12,       0, 0, 32'h4});
    vecs.push_back('{ADD,   4, 32'h10,    32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        0, 0, 32'h14});
    vecs.push_back('{SUB,   5, 32'h0,     32'd0,        32'd1,        32'h0,        32'hFFFFFFFF, 0, 0, 32'h4});
    vecs.push_back('{SRA,   6, 32'h0,     32'h80000000, 32'h24,       32'h0,        32'hF8000000, 0, 0, 32'h4});
    vecs.push_back('{SRL,   7, 32'h0,     32'h80000000, 32'h24,       32'h0,        32'h08000000, 0, 0, 32'h4});
    vecs.push_back('{SRAI,  8, 32'h0,     32'h80000000, 32'd8,        32'd4,        32'hF8000000, 0, 0, 32'h4});
    vecs.push_back('{SLLI,  9, 32'h0,     32'd1,        32'd0,        32'd31,       32'h80000000, 0, 0, 32'h4});
    vecs.push_back('{SLTU, 10, 32'h0,     32'd1,        32'hFFFFFFFF, 32'h0,        32'd1,        0, 0, 32'h4});
    vecs.push_back('{SLT,  11, 32'h0,     32'd1,        32'hFFFFFFFF, 32'h0,        32'd0,        0, 0, 32'h4});
    vecs.push_back('{XORI, 12, 32'h0,     32'h0000F0F0, 32'h0,        32'hFFFFFFFF, 32'hFFFF0F0F, 0, 0, 32'h4});
    vecs.push_back('{LUI,  13, 32'h200,   32'h0,        32'h0,        32'h12345000, 32'h12345000, 0, 0, 32'h204});
    vecs.push_back('{AUIPC,14, 32'h1000,  32'h0,        32'h0,        32'h2000,     32'h3000,     0, 0, 32'h1004});
    vecs.push_back('{BLT,  15, 32'h100,   32'hFFFFFFFE, 32'd1,        32'h20,       32'h0,        1, 1, 32'h120});
    vecs.push_back('{BGEU, 16, 32'h100,   32'hFFFFFFFE, 32'd1,        32'h20,       32'h0,        1, 1, 32'h120});
    vecs.push_back('{BEQ,  17, 32'h100,   32'hFFFFFFFE, 32'd1,        32'h20,       32'h0,        1, 0, 32'h104});
    vecs.push_back('{BGE,  18, 32'h100,   32'hFFFFFFFE, 32'd1,        32'h20,       32'h0,        1, 0, 32'h104});
    vecs.push_back('{BLTU, 19, 32'h100,   32'hFFFFFFFE, 32'd1,        32'h20,       32'h0,        1, 0, 32'h104});
    vecs.push_back('{BNE,  20, 32'h100,   32'd9,        32'd9,        32'h20,       32'h0,        1, 0, 32'h104});
    vecs.push_back('{JALR, 21, 32'h40,    32'h1003,     32'h0,        32'h0,        32'h44,       1, 1, 32'h1002});
    vecs.push_back('{JAL,  22, 32'h40,    32'h0,        32'h0,        32'hFFFFFFF8, 32'h44,       1, 1, 32'h38});
    vecs.push_back('{BOGUS,23, 32'h80,    32'd3,        32'd4,        32'd5,        32'h0,        0, 0, 32'h84});

    rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0;
    drive(ADD, 5'd9, 32'h50, 32'd1, 32'd2, 32'd3);
    tick();
    tick();
    check_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // ADD then NOP: one-cycle valid pulse
    drive(ADD, 5'd3, 32'h0, 32'd5, 32'd7, 32'h0);
    tick();
    check_all("add1", 1'b1, 5'd3, 32'd12, 1'b0, 1'b0, 32'h4);
    drive(NOP, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("nop.has", 32'(alu_has_result), 32'd0);
    check("nop.br", 32'(is_branch_out), 32'd0);
    check("nop.tk", 32'(taken_out), 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].pc, vecs[i].vi, vecs[i].vj, vecs[i].imm);
      tick();
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].rd, vecs[i].res, vecs[i].br,
                vecs[i].tk, vecs[i].tgt);
    end

    // Back-to-back ADDIs, rollback with the third
    for (int k = 1; k <= 2; k++) begin
      drive(ADDI, 5'(k), 32'h0, 32'd100, 32'h0, 32'(k));
      tick();
      check_all($sformatf("b2b%0d", k), 1'b1, 5'(k), 32'(100 + k), 1'b0, 1'b0, 32'h4);
    end
    drive(ADDI, 5'd3, 32'h0, 32'd100, 32'h0, 32'd3);
    rollback_signal = 1'b1;
    tick();
    check_all("rollback", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    rollback_signal = 1'b0;

    // Stall: result held while rdy=0, new op loads once rdy returns
    drive(ADD, 5'd7, 32'h20, 32'd10, 32'd20, 32'h0);
    tick();
    check_all("pre_stall", 1'b1, 5'd7, 32'd30, 1'b0, 1'b0, 32'h24);
    rdy = 1'b0;
    drive(JAL, 5'd8, 32'h40, 32'h0, 32'h0, 32'h100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("stall%0d", k), 1'b1, 5'd7, 32'd30, 1'b0, 1'b0, 32'h24);
    end
    rdy = 1'b1;
    tick();
    check_all("post_stall", 1'b1, 5'd8, 32'h44, 1'b1, 1'b1, 32'h140);

    // rst wins over a valid op
    drive(ADD, 5'd2, 32'h0, 32'd1, 32'd1, 32'h0);
    rst = 1'b1;
    tick();
    check("rst_prio.has", 32'(alu_has_result), 32'd0);
    check("rst_prio.res", result_out, 32'h0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution end of the reservation-station → ALU issue interface.
- Each cycle it takes at most one ready RV32I integer/branch/jump op from the reservation station, which registers and holds that op for one cycle.
- It computes the result and broadcasts it on the ALU CDB port (alu_has_result / alias / result) exactly one cycle later, for consumption by the RS, LSB and ROB.
- It also reports branch/jump resolution (taken, target PC) to the ROB.

Parameters:
- DATA_W, 32, operand/result/PC width
- ROB_ID_W, 5, ROB alias width; alias 0 is the renamed-zero tag and never tags a live op
- OP_W, 6, optype width; encodings are the shared OPTYPE_* / NOP definitions

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = pause, all state held
- rollback_signal  in  1  mispredict flush
- optype_in  in  OP_W  op from RS; NOP = no op this cycle
- rd_in  in  ROB_ID_W  destination ROB alias
- pc_in  in  DATA_W  instruction PC
- vi_in  in  DATA_W  rs1 value
- vj_in  in  DATA_W  rs2 value
- imm_in  in  DATA_W  sign-extended immediate (already shifted for LUI/AUIPC)
- alu_has_result  out  1  CDB valid
- alias_out  out  ROB_ID_W  CDB tag
- result_out  out  DATA_W  CDB value (rd write data)
- is_branch_out  out  1  op was a branch/JAL/JALR
- taken_out  out  1  control flow redirected
- target_pc_out  out  DATA_W  redirect target when taken, else pc+4

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, including alu_has_result=0. rst has priority over everything.
- rollback_signal=1 at posedge (rst=0): same clear as reset. The op on the inputs that cycle is dropped.
- rdy=0 (rst=0, rollback=0): every output register holds its value and the input op is ignored. The RS stalls in lockstep.
- Otherwise, at every posedge the output stage loads:
  - alu_has_result = (optype_in != NOP)
  - alias_out = rd_in
  - result / branch fields as defined below
- When optype_in == NOP:
  - alu_has_result=0, is_branch_out=0, taken_out=0.
  - result_out, alias_out, target_pc_out don't care.
- Latency:
  - Op presented in cycle N is visible on the CDB in cycle N+1, valid for exactly one cycle.
  - One op per cycle, fully pipelined, no backpressure.
  - Back-to-back ops give consecutive one-cycle valid pulses.
- Arithmetic: modulo 2^DATA_W. SLT/SLTI/BLT/BGE are signed; SLTU/SLTIU/BLTU/BGEU are unsigned.
- Shifts:
  - Register forms use vj_in[4:0]; immediate forms use imm_in[4:0].
  - SRA/SRAI are arithmetic.
- R-type ops use vj_in; I-type ops use imm_in.
- LUI: result = imm_in.
- AUIPC: result = pc_in + imm_in.
- JAL:
  - result = pc_in + 4
  - is_branch=1, taken=1
  - target = pc_in + imm_in
- JALR:
  - result = pc_in + 4
  - is_branch=1, taken=1
  - target = (vi_in + imm_in) & ~1
- BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - is_branch=1, taken = condition(vi_in, vj_in)
  - target = taken ? pc_in + imm_in : pc_in + 4
  - result_out = 0 (no rd)
- Non-control ops: is_branch=0, taken=0, target_pc = pc_in + 4.
- Unrecognised optype other than NOP:
  - Treated as a result-producing op with result 0, so the ROB entry still completes.
  - alu_has_result=1, taken=0.
- The unit keeps no internal state beyond the single output register stage. There is no cross-cycle forwarding: the RS resolves its own dependencies via the CDB.
- A rollback coinciding with a valid op: the op is lost, and alu_has_result is 0 next cycle.
- rdy falling with a result on the CDB: the result is held (still valid) until rdy rises, then updates at the next posedge.

Test Plan:
- Reset → all outputs 0. Then ADD rd=3, vi=5, vj=7 at N → cycle N+1: has_result=1, alias=3, result=12; cycle N+2 with NOP input: has_result=0.
- SUB vi=0, vj=1 → result 0xFFFFFFFF. SRA vi=0x80000000, vj=0x24 (shamt 4) → 0xF8000000. SLTU vi=1, vj=0xFFFFFFFF → 1; SLT same operands → 0.
- BLT pc=0x100, vi=0xFFFFFFFE, vj=1, imm=0x20 → is_branch=1, taken=1, target=0x120. BGEU with same operands → taken=1. BEQ with unequal operands → taken=0, target=0x104.
- JALR pc=0x40, vi=0x1003, imm=0 → result=0x44, taken=1, target=0x1002. JAL pc=0x40, imm=-8 → target=0x38.
- Three consecutive ADDIs (rd=1,2,3) → three consecutive valid pulses with aliases 1,2,3. Assert rollback with the third op → third pulse suppressed, outputs 0.
- Result valid, then rdy=0 for 3 cycles with a new op on the inputs → outputs frozen on the old result. rdy=1 → next posedge loads the op then present.
